aes_round_ctrl: RTL and testbench

- Sequencing controller for the iterative AES-128 encryption datapath. Accepts a job, pulses the datapath load, then steps the round datapath through rounds 1..NR, flagging the final round (no MixColumns).
- Generates each round key on the fly (one key-schedule step per round) using the datapath's shared S-box via a 32-bit side port.
- Presents a valid/ready result handshake to the consumer.

---
 rtl/aes_round_ctrl.sv | 151 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Purpose: sequencing controller for an iterative AES-128 encryption datapath. It loads the job,
//          steps rounds 1..NR and expands each round key on the fly through a shared S-box side port.
// Latency: accept at T, rounds 1..NR-1 at T+1..T+NR-1, final round at T+NR, out_valid from T+NR+1.
// Backpressure: out_valid is held in DONE until out_ready=1. in_ready is high only in IDLE, so start
//          is ignored while a job is in flight.
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   start, key         : job request and cipher key (key is sampled in the accept cycle)
//   in_ready           : controller is idle and can accept a job
//   dp_load            : pulse; the datapath loads plaintext ^ key
//   dp_round_en        : the datapath applies one round using round_key
//   dp_final           : qualifies dp_round_en; this is the last round, with no MixColumns
//   round_idx          : round being applied (1..NR), 0 otherwise
//   round_key          : key for the current round; zero when no round is active
//   ks_word_out        : RotWord(w3) sent to the shared S-box
//   ks_word_in         : SubWord(ks_word_out), returned combinationally
//   out_valid          : result handshake
//   out_ready          : result handshake
//   busy               : a job is in flight (ROUND, FINAL or DONE)
module aes_round_ctrl #(
  // Only 10 (AES-128) is meaningful; the rcon progression is sized for exactly 10 key steps.
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         in_ready,
  output logic         dp_load,
  output logic         dp_round_en,
  output logic         dp_final,
  output logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic [31:0]  ks_word_out,
  input  logic [31:0]  ks_word_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NR_W      = 4'(NR);
  localparam logic [3:0] LAST_STEP = 4'(NR - 1);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [127:0] step_key;
  logic [7:0]   rcon_next;

  // One key-schedule step. key_q holds the previous round key, so its result is the key
  // for the round currently being applied.
  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign ks_word_out = {w3[23:0], w3[31:24]};
  assign t           = ks_word_in ^ {rcon_q, 24'h0};
  assign n0          = w0 ^ t;
  assign n1          = w1 ^ n0;
  assign n2          = w2 ^ n1;
  assign n3          = w3 ^ n2;
  assign step_key    = {n0, n1, n2, n3};

  // Multiplication by x in GF(2^8): 01 02 04 ... 80 1b 36.
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // The key is zeroed outside round cycles so the port does not expose a stale schedule word.
  assign round_key = dp_round_en ? step_key : 128'h0;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    rcon_d      = rcon_q;
    round_d     = round_q;
    in_ready    = 1'b0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_final    = 1'b0;
    round_idx   = 4'd0;
    out_valid   = 1'b0;
    busy        = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (start) begin
          dp_load = 1'b1;
          key_d   = key;
          rcon_d  = 8'h01;
          round_d = 4'd1;
          state_d = (NR == 1) ? S_FINAL : S_ROUND;
        end
      end
      S_ROUND: begin
        dp_round_en = 1'b1;
        round_idx   = round_q;
        key_d       = step_key;
        rcon_d      = rcon_next;
        round_d     = round_q + 4'd1;
        if (round_q == LAST_STEP) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        // key_q and rcon_q are left alone; the schedule is not needed after this round.
        dp_round_en = 1'b1;
        dp_final    = 1'b1;
        round_idx   = NR_W;
        state_d     = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= 128'h0;
      rcon_q  <= 8'h01;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Purpose: self-checking bench for aes_round_ctrl. It uses a FIPS-197 key-expansion model and a
//          per-cycle compare process, then runs directed jobs followed by randomized traffic.
// Latency: the model tracks the number of cycles since accept (phase 1..10 = rounds, 11 = done).
// Backpressure: out_ready is driven both by the directed sequence and at random.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         in_ready;
  logic         dp_load;
  logic         dp_round_en;
  logic         dp_final;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic [31:0]  ks_word_out;
  logic [31:0]  ks_word_in;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants, written out by hand.
  logic [7:0] rcon_tbl [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Shared S-box model on the side port.
  assign ks_word_in = subword(ks_word_out);

  aes_round_ctrl #(.NR(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key         (key),
    .in_ready    (in_ready),
    .dp_load     (dp_load),
    .dp_round_en (dp_round_en),
    .dp_final    (dp_final),
    .round_idx   (round_idx),
    .round_key   (round_key),
    .ks_word_out (ks_word_out),
    .ks_word_in  (ks_word_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  logic [127:0] rk [0:10];
  int phase = 0;

  // Textbook FIPS-197 expansion into 44 words.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rcon_tbl[i / 4 - 1], 24'h0};
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  always @(posedge clk) begin
    if (rst) begin
      phase <= 0;
    end else if (phase == 0) begin
      if (start) begin
        expand(key);
        phase <= 1;
      end
    end else if (phase <= 10) begin
      phase <= phase + 1;
    end else if (out_ready) begin
      phase <= 0;
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] pw;
    logic [7:0]  rc_obs;
    if (chk_en) begin
      check("in_ready", in_ready, phase == 0);
      check("busy", busy, phase != 0);
      check("dp_load", dp_load, (phase == 0) && start);
      check("dp_round_en", dp_round_en, (phase >= 1) && (phase <= 10));
      check("dp_final", dp_final, phase == 10);
      check("out_valid", out_valid, phase == 11);
      check("round_idx", round_idx, (phase >= 1 && phase <= 10) ? phase[3:0] : 4'd0);
      if (phase >= 1 && phase <= 10) begin
        pw = rk[phase - 1][31:0];
        check("round_key", round_key, rk[phase]);
        check("ks_word_out", ks_word_out, {pw[23:0], pw[31:24]});
        rc_obs = round_key[127:120] ^ rk[phase - 1][127:120] ^ ks_word_in[31:24];
        check("rcon", rc_obs, rcon_tbl[phase - 1]);
      end
    end
  end

  // ---------------- Stimulus ----------------
  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept a job and walk it to the first out_valid cycle. The task returns just after that
  // cycle's negedge, with literal checks made at the accept, round 1 and final-round cycles.
  task automatic job(input logic [127:0] k, input logic [127:0] r1, input logic [127:0] r10,
                     input bit glitch);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    check("lit_load_T", dp_load, 1'b1);
    tick();
    for (int c = 1; c <= 10; c++) begin
      start = glitch && (c == 3 || c == 7);
      key   = rnd128();
      @(negedge clk);
      check("lit_load_off", dp_load, 1'b0);
      if (c == 1) begin
        check("lit_r1_idx", round_idx, 4'd1);
        check("lit_r1_key", round_key, r1);
      end
      if (c == 10) begin
        check("lit_r10_final", dp_final, 1'b1);
        check("lit_r10_idx", round_idx, 4'd10);
        check("lit_r10_key", round_key, r10);
      end
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    check("lit_out_valid", out_valid, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    key       = 128'h0;
    out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_reset_in_ready", in_ready, 1'b1);
    check("lit_reset_idx", round_idx, 4'd0);

    // Pin the model itself against the published expansions.
    expand(K_FIPS);
    check("model_fips_r1", rk[1], F_R1);
    check("model_fips_r10", rk[10], F_R10);
    expand(128'h0);
    check("model_zero_r1", rk[1], Z_R1);
    check("model_zero_r10", rk[10], Z_R10);
    tick();

    // FIPS job with start pulses and key changes mid-job, then 5 cycles of backpressure.
    job(K_FIPS, F_R1, F_R10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("lit_hold_valid", out_valid, 1'b1);
      check("lit_hold_no_round", dp_round_en, 1'b0);
    end
    tick();
    out_ready = 1'b1;
    start     = 1'b1;
    key       = rnd128();
    @(negedge clk);
    check("lit_done_no_accept", dp_load, 1'b0);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("lit_idle_after_done", in_ready, 1'b1);
    check("lit_valid_dropped", out_valid, 1'b0);
    tick();

    // Back-to-back jobs with the all-zero key.
    for (int j = 0; j < 2; j++) begin
      job(128'h0, Z_R1, Z_R10, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Reset in the middle of the ROUND phase.
    start = 1'b1;
    key   = K_FIPS;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_rst_in_ready", in_ready, 1'b1);
    check("lit_rst_round_en", dp_round_en, 1'b0);
    check("lit_rst_idx", round_idx, 4'd0);
    check("lit_rst_valid", out_valid, 1'b0);
    tick();
    job(K_FIPS, F_R1, F_R10, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 2) == 0);
      key       = rnd128();
      out_ready = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
